// File: rtl/cmd_triangle_serializer.sv
// Triangle command serializer: widens one triangle_t to the wire layout and
// streams it MSB-first as bytes. Option macro: CMD_SER_CHECKSUM_EN (XOR byte).
package types_pkg;

    typedef logic signed [24:0] fixed_q11x14;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        rgb444_t     color;
        fixed_q11x14 x;
        fixed_q11x14 y;
        fixed_q11x14 z;
    } vertex_t;

    typedef struct packed {
        vertex_t v0;
        vertex_t v1;
        vertex_t v2;
    } triangle_t;

    typedef struct packed {
        logic [15:0] color;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } cmd_vertex_t;

    typedef struct packed {
        cmd_vertex_t v0;
        cmd_vertex_t v1;
        cmd_vertex_t v2;
    } cmd_triangle_t;

    function automatic logic [31:0] cvt_pos(fixed_q11x14 p);
        return {{5{p[24]}}, p, 2'b00};
    endfunction

    function automatic logic [15:0] cvt_color(rgb444_t c);
        return {c.r, c.r[3], c.g, c.g[3:2], c.b, c.b[3]};
    endfunction

    function automatic cmd_vertex_t cvt_vertex(vertex_t v);
        cmd_vertex_t w;
        w.color = cvt_color(v.color);
        w.x     = cvt_pos(v.x);
        w.y     = cvt_pos(v.y);
        w.z     = cvt_pos(v.z);
        return w;
    endfunction

endpackage

module cmd_triangle_serializer
    import types_pkg::*;
#(
    parameter int PIPE_ACCEPT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  triangle_t  in_triangle,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy
);

    localparam logic [5:0] LAST_IDX = 6'd41;

`ifdef CMD_SER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

    state_t        state;
    logic [335:0]  shreg;
    logic [5:0]    cnt;
    logic          rdy_q;
    cmd_triangle_t wide;
    logic          accept;
    logic          fire;
`ifdef CMD_SER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    // widen the incoming triangle to the wire layout
    always_comb begin
        wide    = '0;
        wide.v0 = cvt_vertex(in_triangle.v0);
        wide.v1 = cvt_vertex(in_triangle.v1);
        wide.v2 = cvt_vertex(in_triangle.v2);
    end

    assign in_ready = !rst && (rdy_q ||
                      (PIPE_ACCEPT != 0 && out_valid && out_last && out_ready));
    assign accept   = in_valid && in_ready;
    assign fire     = out_valid && out_ready;
    assign out_data = shreg[335:328];
    assign busy     = (state != IDLE);

    // frame sequencer: load on accept, shift one byte per handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            rdy_q     <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef CMD_SER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    rdy_q <= 1'b1;
                end
                SEND: begin
                    if (fire) begin
                        shreg <= shreg << 8;
                        cnt   <= cnt + 6'd1;
`ifdef CMD_SER_CHECKSUM_EN
                        csum  <= csum ^ out_data;
                        if (cnt == LAST_IDX) begin
                            state    <= CSUM;
                            shreg    <= {csum ^ out_data, 328'd0};
                            out_last <= 1'b1;
                        end
`else
                        if (cnt == LAST_IDX - 6'd1)
                            out_last <= 1'b1;
                        if (cnt == LAST_IDX) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            rdy_q     <= 1'b1;
                        end
`endif
                    end
                end
`ifdef CMD_SER_CHECKSUM_EN
                CSUM: begin
                    if (fire) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        rdy_q     <= 1'b1;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase

            if (accept) begin
                state     <= SEND;
                shreg     <= wide;
                cnt       <= '0;
                rdy_q     <= 1'b0;
                out_valid <= 1'b1;
                out_last  <= 1'b0;
`ifdef CMD_SER_CHECKSUM_EN
                csum      <= '0;
`endif
            end
        end
    end

endmodule
